m_univ_shiftreg: RTL and testbench

Parametrised universal shift register, the successor to the fixed 4-bit serial-in/parallel-out register. It has a configurable width, bidirectional serial shifting, synchronous parallel load, a clock enable and serial-out taps at both ends. A shift counter raises a word-complete strobe after WIDTH consecutive same-direction shifts. It sits between serial links and parallel datapaths and works as a SIPO, PISO or bidirectional shifter.

---
 rtl/m_univ_shiftreg.sv | 46 ++++
 tb/tb_m_univ_shiftreg.sv | 131 +++++++++++++
 2 files changed

// File: rtl/m_univ_shiftreg.sv
// m_univ_shiftreg: parametrised bidirectional shift register with parallel load and word-complete strobe
module m_univ_shiftreg #(
  parameter int WIDTH = 4,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic             SI,
  input  logic [WIDTH-1:0] PI,
  output logic [WIDTH-1:0] PO,
  output logic             SO_UP,
  output logic             SO_DN,
  output logic             WORD_VLD,
  output logic [CW-1:0]    BITCNT
);
  logic dir;
  assign SO_UP = PO[WIDTH-1];
  assign SO_DN = PO[0];
  // register, counter, strobe and direction update; MODE[1] on a shift is the direction (1 = down)
  always_ff @(posedge CLK) begin
    if (CLR) begin
      PO       <= '0;
      BITCNT   <= '0;
      WORD_VLD <= 1'b0;
      dir      <= 1'b0;
    end else if (!EN || MODE == 2'b00) begin
      WORD_VLD <= 1'b0;
    end else if (MODE == 2'b11) begin
      PO       <= PI;
      BITCNT   <= '0;
      WORD_VLD <= 1'b0;
    end else begin
      PO <= MODE[0] ? {PO[WIDTH-2:0], SI} : {SI, PO[WIDTH-1:1]};
      if (MODE[1] != dir) begin
        dir      <= MODE[1];
        BITCNT   <= CW'(1);
        WORD_VLD <= 1'b0;
      end else begin
        BITCNT   <= (BITCNT == CW'(WIDTH - 1)) ? '0 : BITCNT + CW'(1);
        WORD_VLD <= (BITCNT == CW'(WIDTH - 1));
      end
    end
  end
endmodule

// File: tb/tb_m_univ_shiftreg.sv
// tb_m_univ_shiftreg: scoreboard bench for m_univ_shiftreg at WIDTH=4 and WIDTH=8
module tb_m_univ_shiftreg;
  typedef struct {
    logic       w8;
    logic [7:0] po;
    logic [2:0] cnt;
    logic       vld;
    string      name;
  } exp_t;

  localparam logic [1:0] HOLD = 2'b00, UP = 2'b01, DN = 2'b10, LD = 2'b11;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = HOLD;
  logic       si = 1'b0;
  logic [3:0] pi4 = '0;
  logic [7:0] pi8 = '0;
  logic [3:0] po4;
  logic [7:0] po8;
  logic       sou4, sod4, vld4, sou8, sod8, vld8;
  logic [1:0] cnt4;
  logic [2:0] cnt8;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  m_univ_shiftreg #(.WIDTH(4)) u4 (
    .CLK(clk), .CLR(clr), .EN(en), .MODE(mode), .SI(si), .PI(pi4),
    .PO(po4), .SO_UP(sou4), .SO_DN(sod4), .WORD_VLD(vld4), .BITCNT(cnt4)
  );

  m_univ_shiftreg #(.WIDTH(8)) u8 (
    .CLK(clk), .CLR(clr), .EN(en), .MODE(mode), .SI(si), .PI(pi8),
    .PO(po8), .SO_UP(sou8), .SO_DN(sod8), .WORD_VLD(vld8), .BITCNT(cnt8)
  );

  always #5 clk = ~clk;

  // monitor: pop one expectation per cycle and compare away from the active edge
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      logic [13:0] act, req;
      e = q.pop_front();
      act = e.w8 ? {po8, cnt8, vld8, sou8, sod8} : {4'b0, po4, 1'b0, cnt4, vld4, sou4, sod4};
      req = {e.po, e.cnt, e.vld, e.w8 ? e.po[7] : e.po[3], e.po[0]};
      checks++;
      if (act !== req) begin
        errors++;
        $display("FAIL %s: got po=%h cnt=%0d vld=%b so_up=%b so_dn=%b, want po=%h cnt=%0d vld=%b so_up=%b so_dn=%b",
                 e.name, act[13:6], act[5:3], act[2], act[1], act[0],
                 req[13:6], req[5:3], req[2], req[1], req[0]);
      end
    end
  end

  task automatic step(input logic c, input logic e, input logic [1:0] m, input logic s,
                      input logic [7:0] p, input logic chk, input logic w8,
                      input logic [7:0] xpo, input logic [2:0] xcnt, input logic xvld, input string nm);
    clr = c; en = e; mode = m; si = s; pi4 = p[3:0]; pi8 = p;
    @(posedge clk);
    #1;
    if (chk) q.push_back('{w8: w8, po: xpo, cnt: xcnt, vld: xvld, name: nm});
  endtask

  initial begin
    step(1, 0, HOLD, 0, 8'h00, 0, 0, 8'h0, 0, 0, "");
    for (int i = 0; i < 6; i++)
      step(0, 1, 2'($urandom_range(0, 3)), 1'($urandom), 8'($urandom), 0, 0, 8'h0, 0, 0, "");
    step(1, 1, LD, 0, 8'hFF, 1, 0, 8'h0, 0, 0, "reset");
    // SIPO
    step(0, 1, UP, 1, 8'h00, 1, 0, 8'h1, 1, 0, "sipo1");
    step(0, 1, UP, 0, 8'h00, 1, 0, 8'h2, 2, 0, "sipo2");
    step(0, 1, UP, 1, 8'h00, 1, 0, 8'h5, 3, 0, "sipo3");
    step(0, 1, UP, 1, 8'h00, 1, 0, 8'hB, 0, 1, "sipo4");
    step(0, 1, HOLD, 0, 8'h00, 1, 0, 8'hB, 0, 0, "sipo_hold");
    // PISO
    step(1, 1, HOLD, 0, 8'h00, 1, 0, 8'h0, 0, 0, "piso_clr");
    step(0, 1, LD, 0, 8'h09, 1, 0, 8'h9, 0, 0, "piso_load");
    step(0, 1, DN, 0, 8'h00, 1, 0, 8'h4, 1, 0, "piso1");
    step(0, 1, DN, 0, 8'h00, 1, 0, 8'h2, 2, 0, "piso2");
    step(0, 1, DN, 0, 8'h00, 1, 0, 8'h1, 3, 0, "piso3");
    step(0, 1, DN, 0, 8'h00, 1, 0, 8'h0, 0, 1, "piso4");
    // stall
    step(1, 1, HOLD, 0, 8'h00, 1, 0, 8'h0, 0, 0, "stall_clr");
    step(0, 1, UP, 1, 8'h00, 1, 0, 8'h1, 1, 0, "stall_up1");
    step(0, 1, UP, 1, 8'h00, 1, 0, 8'h3, 2, 0, "stall_up2");
    step(0, 0, UP, 0, 8'h00, 1, 0, 8'h3, 2, 0, "stall_en0a");
    step(0, 0, UP, 1, 8'h00, 1, 0, 8'h3, 2, 0, "stall_en0b");
    step(0, 0, LD, 1, 8'hFF, 1, 0, 8'h3, 2, 0, "stall_en0c");
    step(0, 1, UP, 0, 8'h00, 1, 0, 8'h6, 3, 0, "stall_up3");
    step(0, 1, UP, 0, 8'h00, 1, 0, 8'hC, 0, 1, "stall_up4");
    // direction change, back-to-back word, load and clear mid-word
    step(1, 1, HOLD, 0, 8'h00, 1, 0, 8'h0, 0, 0, "dir_clr");
    step(0, 1, UP, 1, 8'h00, 1, 0, 8'h1, 1, 0, "dir_up1");
    step(0, 1, UP, 1, 8'h00, 1, 0, 8'h3, 2, 0, "dir_up2");
    step(0, 1, DN, 0, 8'h00, 1, 0, 8'h1, 1, 0, "dir_dn1");
    step(0, 1, DN, 1, 8'h00, 1, 0, 8'h8, 2, 0, "dir_dn2");
    step(0, 1, DN, 0, 8'h00, 1, 0, 8'h4, 3, 0, "dir_dn3");
    step(0, 1, DN, 1, 8'h00, 1, 0, 8'hA, 0, 1, "dir_dn4");
    step(0, 1, DN, 1, 8'h00, 1, 0, 8'hD, 1, 0, "b2b_dn1");
    step(0, 1, LD, 0, 8'h06, 1, 0, 8'h6, 0, 0, "midload");
    step(0, 1, UP, 1, 8'h00, 1, 0, 8'hD, 1, 0, "load_up1");
    step(0, 1, UP, 0, 8'h00, 1, 0, 8'hA, 2, 0, "load_up2");
    step(1, 1, UP, 1, 8'h00, 1, 0, 8'h0, 0, 0, "midclr");
    step(0, 1, UP, 1, 8'h00, 1, 0, 8'h1, 1, 0, "clr_up1");
    // WIDTH=8 regression: 0xA5 shifted in MSB first
    step(1, 1, HOLD, 0, 8'h00, 1, 1, 8'h00, 0, 0, "w8_clr");
    step(0, 1, UP, 1, 8'h00, 1, 1, 8'h01, 1, 0, "w8_s1");
    step(0, 1, UP, 0, 8'h00, 1, 1, 8'h02, 2, 0, "w8_s2");
    step(0, 1, UP, 1, 8'h00, 1, 1, 8'h05, 3, 0, "w8_s3");
    step(0, 1, UP, 0, 8'h00, 1, 1, 8'h0A, 4, 0, "w8_s4");
    step(0, 1, UP, 0, 8'h00, 1, 1, 8'h14, 5, 0, "w8_s5");
    step(0, 1, UP, 1, 8'h00, 1, 1, 8'h29, 6, 0, "w8_s6");
    step(0, 1, UP, 0, 8'h00, 1, 1, 8'h52, 7, 0, "w8_s7");
    step(0, 1, UP, 1, 8'h00, 1, 1, 8'hA5, 0, 1, "w8_s8");
    for (int i = 0; i < 3; i++)
      step(0, 1, HOLD, 1, 8'hFF, 1, 1, 8'hA5, 0, 0, "w8_hold");
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
